tl_slave_responder: RTL and testbench
=====================================

// Module: tl_slave_responder
// PURPOSE
//  Synthesizable TileLink-UL responder (A in, D out) that sits on the far end of the bus the TL monitor watches.
//  Acts as a backing-memory slave for the bench: Get, PutFullData and PutPartialData are served from an internal
//  array. Every other opcode is answered with denied. Handles one transaction at a time; supports multi-beat bursts.
// PARAMETERS
//  SIZE_WD    3    width of a_size/d_size (log2 bytes)
//  ADDR_WD    36   address width
//  DATA_WD    256  beat width; MASK_WD = DATA_WD/8; BOFF = log2(MASK_WD)
//  SOURCE_WD  32   source id width
//  SINK_WD    32   sink id width
//  MEM_DEPTH  256  memory entries of DATA_WD bits (power of 2); IDX = log2(MEM_DEPTH)
//  RESP_LAT   2    idle cycles between last A beat and first D beat (0..15)
// PORTS
//  clock      in   1          single clock, posedge
//  reset      in   1          asynchronous, active-high
//  a_opcode   in   3          TL A opcode
//  a_param    in   3          ignored
//  a_size     in   SIZE_WD    log2 transfer bytes
//  a_source   in   SOURCE_WD  requester id, echoed on D
//  a_address  in   ADDR_WD    byte address
//  a_mask     in   MASK_WD    byte enables
//  a_data     in   DATA_WD    write data
//  a_corrupt  in   1          Put beat with corrupt=1 is not written
//  a_valid    in   1          A handshake
//  a_ready    out  1          A handshake
//  d_opcode   out  3          0 AccessAck, 1 AccessAckData, 2 HintAck
//  d_param    out  2          always 0
//  d_size     out  SIZE_WD    = captured a_size
//  d_source   out  SOURCE_WD  = captured a_source
//  d_sink     out  SINK_WD    always 0
//  d_denied   out  1          error response
//  d_data     out  DATA_WD    read data
//  d_corrupt  out  1          = d_denied on data-bearing responses, else 0
//  d_valid    out  1          D handshake
//  d_ready    in   1          D handshake
// BEHAVIOUR
//  - Reset values: a_ready=0 while reset is high, d_valid=0, all other d_* = 0, FSM=IDLE, counters=0.
//    The memory array is not reset.
//  - beats = (a_size > BOFF) ? 2^(a_size-BOFF) : 1.
//    Data-bearing A opcodes (0,1,2,3) take `beats` beats; all other A opcodes take 1 beat.
//  - Transfer occurs when valid && ready in the same cycle. A beats are counted with a wrapping beat counter.
//  - FSM states and transitions:
//    IDLE: a_ready=1. On the first-beat handshake, capture opcode/size/source/address and compute the error flag.
//      Go to A_BEATS if more beats remain, otherwise go to WAIT.
//    A_BEATS: a_ready=1. Go to WAIT when the last beat is accepted.
//    WAIT: a_ready=0. Count RESP_LAT cycles, then go to RESP.
//    RESP: d_valid=1. Go to IDLE after the last D beat handshake. a_ready stays 0 in the cycle of that handshake.
//  - Latency: last A beat accepted in cycle t -> first d_valid in cycle t+1+RESP_LAT.
//  - Response beat counts:
//    Get: AccessAckData with `beats` beats.
//    Put: AccessAck, 1 beat.
//  - Memory index = (address[ADDR_WD-1:BOFF] + beat) mod MEM_DEPTH; wraps at MEM_DEPTH without error.
//  - Put: each accepted beat writes bytes where a_mask=1, in the cycle of its handshake.
//  - Get: d_data = mem[index] of the current D beat. A write in the same cycle is not visible to that read.
//  - Error flag (denied=1) is set if address[a_size-1:0] != 0 (misaligned) or a_opcode is not in {0,1,4,5}.
//    An errored Put/Get does not access memory.
//  - Opcode 5 (Intent): HintAck, denied=0.
//  - Opcodes 2 and 3: AccessAckData, `beats` beats, data=0, denied=1, corrupt=1.
//  - Opcodes 6 and 7: AccessAck, denied=1.
//  - Once asserted, d_valid and all d_* fields hold stable until the handshake.
//  - Async reset mid-transaction: the transaction is dropped, the FSM returns to IDLE, no D beat is emitted.
// CONFIGURATION
//  - TL_SLAVE_BACKPRESSURE_EN defined:
//    16-bit LFSR (x^16+x^14+x^13+x^11+1), reset seed 16'hACE1, advances every cycle.
//    a_ready = state_ready & lfsr[0].
//    The RESP->d_valid rise is additionally delayed until a cycle where lfsr[1]=1. It never retracts once raised.
//  - TL_SLAVE_BACKPRESSURE_EN undefined: no LFSR; timing exactly as stated above.
// TESTING
//  - Reset release, idle bus -> a_ready=1 the cycle after release, d_valid=0.
//  - PutFull size=5 addr=0x40 data=0xA5..A5 mask=all ones source=7 -> exactly 3 cycles later: AccessAck, source=7, denied=0.
//  - Get size=5 addr=0x40 after the Put -> AccessAckData, data=0xA5..A5, d_size=5.
//  - PutFull size=6 addr=0x100 (2 beats, D0/D1), then Get same -> 2 D beats D0,D1.
//    Hold d_ready=0 for 4 cycles -> data stays stable.
//  - Get size=6 addr=0x120 (misaligned) -> 2 beats, denied=1, corrupt=1, memory unchanged.
//    Opcode 6 -> AccessAck denied=1.
//  - Assert reset during WAIT of a Get -> no d_valid. Next PutPartial mask=0x1 to addr 0x0 writes byte 0 only.

Source files
------------

// File: rtl/tl_slave_responder.sv
// tl_slave_responder: TileLink-UL backing-memory slave (A channel in, D channel out).
// Serves Get / PutFullData / PutPartialData from an internal block-RAM array and
// answers every other opcode with a denied (or HintAck) response. One transaction
// is in flight at a time; multi-beat bursts are supported on both channels.
// Optional build macro TL_SLAVE_BACKPRESSURE_EN adds LFSR-driven A-channel
// backpressure and a randomised delay on the first D beat.
module tl_slave_responder #(
    parameter int SIZE_WD   = 3,
    parameter int ADDR_WD   = 36,
    parameter int DATA_WD   = 256,
    parameter int SOURCE_WD = 32,
    parameter int SINK_WD   = 32,
    parameter int MEM_DEPTH = 256,
    parameter int RESP_LAT  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           a_opcode,
    input  logic [2:0]           a_param,
    input  logic [SIZE_WD-1:0]   a_size,
    input  logic [SOURCE_WD-1:0] a_source,
    input  logic [ADDR_WD-1:0]   a_address,
    input  logic [DATA_WD/8-1:0] a_mask,
    input  logic [DATA_WD-1:0]   a_data,
    input  logic                 a_corrupt,
    input  logic                 a_valid,
    output logic                 a_ready,
    output logic [2:0]           d_opcode,
    output logic [1:0]           d_param,
    output logic [SIZE_WD-1:0]   d_size,
    output logic [SOURCE_WD-1:0] d_source,
    output logic [SINK_WD-1:0]   d_sink,
    output logic                 d_denied,
    output logic [DATA_WD-1:0]   d_data,
    output logic                 d_corrupt,
    output logic                 d_valid,
    input  logic                 d_ready
);

    localparam int MASK_WD = DATA_WD / 8;
    localparam int BOFF    = $clog2(MASK_WD);
    localparam int IDX     = $clog2(MEM_DEPTH);
    localparam int BEAT_WD = 2 ** SIZE_WD;
    localparam logic [3:0] LAT_M1 = 4'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_INTENT   = 3'd5;

    typedef enum logic [1:0] {IDLE, A_BEATS, WAIT, RESP} state_t;

    // Number of beats minus one for a transfer of 2^sz bytes.
    function automatic logic [BEAT_WD-1:0] beats_m1(input logic [SIZE_WD-1:0] sz);
        if (sz > SIZE_WD'(BOFF))
            return (BEAT_WD'(1) << (sz - SIZE_WD'(BOFF))) - BEAT_WD'(1);
        else
            return '0;
    endfunction

    state_t               state_q, state_d;
    logic [2:0]           a_op_q, a_op_d;
    logic [SIZE_WD-1:0]   size_q, size_d;
    logic [SOURCE_WD-1:0] source_q, source_d;
    logic [IDX-1:0]       base_q, base_d;
    logic                 err_q, err_d;
    logic [BEAT_WD-1:0]   a_m1_q, a_m1_d;
    logic [BEAT_WD-1:0]   d_m1_q, d_m1_d;
    logic [BEAT_WD-1:0]   a_beat_q, a_beat_d;
    logic [BEAT_WD-1:0]   d_beat_q, d_beat_d;
    logic [3:0]           wait_q, wait_d;
    logic [2:0]           resp_op_q, resp_op_d;
    logic                 data_resp_q, data_resp_d;
    logic                 rd_ok_q, rd_ok_d;
    logic                 ready_en_q;

    logic                 state_ready;
    logic                 in_resp;
    logic                 a_fire;
    logic                 d_fire;
    logic                 unused_ok;

    // First-beat decode straight from the A channel.
    logic                 new_mis;
    logic                 new_err;
    logic                 new_data_resp;
    logic [2:0]           new_resp_op;
    logic [BEAT_WD-1:0]   new_a_m1;
    logic [BEAT_WD-1:0]   new_d_m1;

    // Memory access.
    logic [DATA_WD-1:0]   mem [MEM_DEPTH];
    logic [DATA_WD-1:0]   rd_q;
    logic                 rd_en;
    logic [IDX-1:0]       rd_idx;
    logic                 wr_en;
    logic [IDX-1:0]       wr_idx;
    logic                 cur_is_put;
    logic                 cur_err;
    logic [IDX-1:0]       cur_base;

    assign unused_ok = ^a_param;

    assign new_mis       = (a_address & ((ADDR_WD'(1) << a_size) - ADDR_WD'(1))) != '0;
    assign new_err       = new_mis || !((a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART) ||
                                        (a_opcode == OP_GET) || (a_opcode == OP_INTENT));
    assign new_data_resp = (a_opcode == 3'd2) || (a_opcode == 3'd3) || (a_opcode == OP_GET);
    assign new_resp_op   = new_data_resp ? 3'd1 : ((a_opcode == OP_INTENT) ? 3'd2 : 3'd0);
    assign new_a_m1      = (a_opcode <= 3'd3) ? beats_m1(a_size) : '0;
    assign new_d_m1      = new_data_resp ? beats_m1(a_size) : '0;

    assign state_ready = (state_q == IDLE) || (state_q == A_BEATS);
    assign in_resp     = (state_q == RESP);

`ifdef TL_SLAVE_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        shown_q;
    logic        shown_d;

    // Free-running LFSR (x^16+x^14+x^13+x^11+1) and the sticky "D already shown" flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q  <= 16'hACE1;
            shown_q <= 1'b0;
        end else begin
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            shown_q <= shown_d;
        end
    end

    assign a_ready = ready_en_q & state_ready & lfsr_q[0];
    assign d_valid = in_resp & (shown_q | lfsr_q[1]);
    assign shown_d = d_valid & (state_d == RESP);
`else
    assign a_ready = ready_en_q & state_ready;
    assign d_valid = in_resp;
`endif

    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    // Writes use the live A fields on the first beat, the captured ones afterwards.
    assign cur_is_put = (state_q == IDLE) ? ((a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART))
                                          : ((a_op_q == OP_PUT_FULL) || (a_op_q == OP_PUT_PART));
    assign cur_err    = (state_q == IDLE) ? new_err : err_q;
    assign cur_base   = (state_q == IDLE) ? a_address[BOFF +: IDX] : base_q;
    assign wr_en      = a_fire & cur_is_put & ~cur_err & ~a_corrupt;
    assign wr_idx     = cur_base + IDX'(a_beat_q);

    // Pre-fetch the next D beat whenever RESP is entered or a D beat is consumed.
    assign rd_en  = (state_d == RESP) && ((state_q != RESP) || d_fire);
    assign rd_idx = base_d + IDX'(d_beat_d);

    // Next-state and capture logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        a_op_d      = a_op_q;
        size_d      = size_q;
        source_d    = source_q;
        base_d      = base_q;
        err_d       = err_q;
        a_m1_d      = a_m1_q;
        d_m1_d      = d_m1_q;
        a_beat_d    = a_beat_q;
        d_beat_d    = d_beat_q;
        wait_d      = wait_q;
        resp_op_d   = resp_op_q;
        data_resp_d = data_resp_q;
        rd_ok_d     = rd_ok_q;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    a_op_d      = a_opcode;
                    size_d      = a_size;
                    source_d    = a_source;
                    base_d      = a_address[BOFF +: IDX];
                    err_d       = new_err;
                    a_m1_d      = new_a_m1;
                    d_m1_d      = new_d_m1;
                    resp_op_d   = new_resp_op;
                    data_resp_d = new_data_resp;
                    rd_ok_d     = (a_opcode == OP_GET) && !new_err;
                    d_beat_d    = '0;
                    wait_d      = '0;
                    if (new_a_m1 != '0) begin
                        a_beat_d = BEAT_WD'(1);
                        state_d  = A_BEATS;
                    end else begin
                        a_beat_d = '0;
                        state_d  = (RESP_LAT == 0) ? RESP : WAIT;
                    end
                end
            end
            A_BEATS: begin
                if (a_fire) begin
                    if (a_beat_q == a_m1_q) begin
                        a_beat_d = '0;
                        state_d  = (RESP_LAT == 0) ? RESP : WAIT;
                    end else begin
                        a_beat_d = a_beat_q + BEAT_WD'(1);
                    end
                end
            end
            WAIT: begin
                if (wait_q == LAT_M1) begin
                    wait_d  = '0;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RESP: begin
                if (d_fire) begin
                    if (d_beat_q == d_m1_q) begin
                        d_beat_d = '0;
                        state_d  = IDLE;
                    end else begin
                        d_beat_d = d_beat_q + BEAT_WD'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; a reset drops any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_op_q      <= '0;
            size_q      <= '0;
            source_q    <= '0;
            base_q      <= '0;
            err_q       <= 1'b0;
            a_m1_q      <= '0;
            d_m1_q      <= '0;
            a_beat_q    <= '0;
            d_beat_q    <= '0;
            wait_q      <= '0;
            resp_op_q   <= '0;
            data_resp_q <= 1'b0;
            rd_ok_q     <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_op_q      <= a_op_d;
            size_q      <= size_d;
            source_q    <= source_d;
            base_q      <= base_d;
            err_q       <= err_d;
            a_m1_q      <= a_m1_d;
            d_m1_q      <= d_m1_d;
            a_beat_q    <= a_beat_d;
            d_beat_q    <= d_beat_d;
            wait_q      <= wait_d;
            resp_op_q   <= resp_op_d;
            data_resp_q <= data_resp_d;
            rd_ok_q     <= rd_ok_d;
            ready_en_q  <= 1'b1;
        end
    end

    // Byte-masked write port and registered read port of the backing memory (not reset).
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < MASK_WD; b++) begin
                if (a_mask[b])
                    mem[wr_idx][b*8 +: 8] <= a_data[b*8 +: 8];
            end
        end
        if (rd_en)
            rd_q <= mem[rd_idx];
    end

    assign d_opcode  = in_resp ? resp_op_q : 3'd0;
    assign d_param   = 2'd0;
    assign d_size    = in_resp ? size_q : '0;
    assign d_source  = in_resp ? source_q : '0;
    assign d_sink    = '0;
    assign d_denied  = in_resp & err_q;
    assign d_corrupt = in_resp & data_resp_q & err_q;
    assign d_data    = (in_resp && rd_ok_q) ? rd_q : '0;

endmodule

// File: tb/tb_tl_slave_responder.sv
// tb_tl_slave_responder: directed and randomised transactions against a
// byte-level memory model; every D beat is compared with a predicted response.
module tb_tl_slave_responder;

    localparam int RESP_LAT = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   a_opcode = '0;
    logic [2:0]   a_param = '0;
    logic [2:0]   a_size = '0;
    logic [31:0]  a_source = '0;
    logic [35:0]  a_address = '0;
    logic [31:0]  a_mask = '0;
    logic [255:0] a_data = '0;
    logic         a_corrupt = 1'b0;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [2:0]   d_opcode;
    logic [1:0]   d_param;
    logic [2:0]   d_size;
    logic [31:0]  d_source;
    logic [31:0]  d_sink;
    logic         d_denied;
    logic [255:0] d_data;
    logic         d_corrupt;
    logic         d_valid;
    logic         d_ready = 1'b0;

    tl_slave_responder #(.RESP_LAT(RESP_LAT)) dut (
        .clock(clock), .reset(reset),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
        .d_valid(d_valid), .d_ready(d_ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memory: data plus a per-byte "has been written" flag.
    logic [255:0] mm [256];
    logic [31:0]  kn [256];

    // Per-beat A stimulus.
    logic [255:0] bd [4];
    logic [31:0]  bm [4];
    bit           bc [4];

    // Predicted response of the current transaction.
    int       e_nb, e_ab, e_db, e_base;
    bit       e_err, e_dres, e_get, e_put;
    logic [2:0] e_op;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Response prediction from the protocol rules.
    task automatic predict(input logic [2:0] op, input logic [2:0] sz, input logic [35:0] addr);
        bit mis;
        e_nb   = (sz > 3'd5) ? (1 << (int'(sz) - 5)) : 1;
        e_ab   = (op <= 3'd3) ? e_nb : 1;
        mis    = (addr % (36'd1 << sz)) != 36'd0;
        e_err  = mis || !(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5);
        e_dres = (op == 3'd2 || op == 3'd3 || op == 3'd4);
        e_op   = e_dres ? 3'd1 : ((op == 3'd5) ? 3'd2 : 3'd0);
        e_db   = e_dres ? e_nb : 1;
        e_get  = (op == 3'd4);
        e_put  = (op == 3'd0 || op == 3'd1);
        e_base = int'(addr[12:5]);
    endtask

    task automatic send_a(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] src,
                          input logic [35:0] addr, output int fire_cyc);
        int n;
        int idx;
        predict(op, sz, addr);
        fire_cyc = 0;
        for (int b = 0; b < e_ab; b++) begin
            a_opcode = op; a_size = sz; a_source = src; a_address = addr;
            a_param = 3'($urandom); a_data = bd[b]; a_mask = bm[b]; a_corrupt = bc[b];
            a_valid = 1'b1;
            n = 0;
            while (!a_ready) begin
                @(negedge clock);
                n++;
                if (n > 50) begin
                    check("a_ready_timeout", a_ready, 1'b1);
                    finish_run();
                end
            end
            fire_cyc = cyc;
            if (e_put && !e_err && !bc[b]) begin
                idx = (e_base + b) % 256;
                for (int i = 0; i < 32; i++) begin
                    if (bm[b][i]) begin
                        mm[idx][i*8 +: 8] = bd[b][i*8 +: 8];
                        kn[idx][i] = 1'b1;
                    end
                end
            end
            @(negedge clock);
        end
        a_valid = 1'b0;
    endtask

    task automatic recv_d(input int fire_cyc, input int hold, input logic [31:0] src, input logic [2:0] sz);
        int n;
        int idx;
        logic [255:0] km;
        logic [255:0] expd;
        n = 0;
        while (!d_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("d_valid_rise", d_valid, 1'b1);
        if (!d_valid) finish_run();
        check("latency", cyc - fire_cyc, 1 + RESP_LAT);
        for (int d = 0; d < e_db; d++) begin
            if (e_get && !e_err) begin
                idx = (e_base + d) % 256;
                expd = mm[idx];
                for (int i = 0; i < 32; i++) km[i*8 +: 8] = kn[idx][i] ? 8'hFF : 8'h00;
            end else begin
                expd = '0;
                km = '1;
            end
            for (int h = 0; h <= hold; h++) begin
                check("d_valid", d_valid, 1'b1);
                check("d_opcode", d_opcode, e_op);
                check("d_source", d_source, src);
                check("d_size", d_size, sz);
                check("d_denied", d_denied, e_err);
                check("d_corrupt", d_corrupt, e_dres && e_err);
                check("d_param_sink", {d_param, d_sink}, '0);
                if (km != '0) check("d_data", d_data & km, expd & km);
                if (h == hold) begin
                    d_ready = 1'b1;
                    if (d == e_db - 1) check("a_ready_in_resp", a_ready, 1'b0);
                end
                @(negedge clock);
            end
            d_ready = 1'b0;
        end
        check("d_valid_after", d_valid, 1'b0);
        check("a_ready_after", a_ready, 1'b1);
    endtask

    task automatic do_txn(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] src,
                          input logic [35:0] addr, input int hold);
        int fc;
        send_a(op, sz, src, addr, fc);
        if (RESP_LAT > 0) check("a_ready_wait", a_ready, 1'b0);
        recv_d(fc, hold, src, sz);
        $display("txn op=%0d size=%0d addr=%h src=%0d beats=%0d err=%0d", op, sz, addr, src, e_db, e_err);
    endtask

    task automatic fill_beats(input logic [2:0] op);
        for (int b = 0; b < 4; b++) begin
            bd[b] = rnd256();
            bm[b] = (op == 3'd1) ? $urandom : 32'hFFFF_FFFF;
            bc[b] = (op <= 3'd1) && ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        int fc;
        logic [7:0]  idx8;
        logic [2:0]  op, sz;
        logic [35:0] addr;
        for (int i = 0; i < 256; i++) begin
            mm[i] = '0;
            kn[i] = '0;
        end
        for (int b = 0; b < 4; b++) begin
            bd[b] = '0; bm[b] = '1; bc[b] = 1'b0;
        end

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_d_fields", {d_opcode, d_size, d_source, d_denied, d_corrupt}, '0);
        check("rst_d_data", d_data, '0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_a_ready", a_ready, 1'b1);
        check("post_rst_d_valid", d_valid, 1'b0);
        $display("txn reset released");

        // Seed a working region of memory, including the top entries.
        for (int i = 0; i < 12; i++) begin
            idx8 = (i < 8) ? 8'(i) : 8'(244 + i);
            fill_beats(3'd0);
            bc[0] = 1'b0;
            do_txn(3'd0, 3'd5, 32'(i), {23'h0, idx8, 5'h0}, 0);
        end

        // PutFull of 0xA5 pattern, then read it back.
        bd[0] = {32{8'hA5}}; bm[0] = '1; bc[0] = 1'b0;
        do_txn(3'd0, 3'd5, 32'd7, 36'h40, 0);
        do_txn(3'd4, 3'd5, 32'd3, 36'h40, 0);

        // Two-beat PutFull and Get with held-off d_ready.
        bd[0] = rnd256(); bd[1] = rnd256(); bm[0] = '1; bm[1] = '1; bc[0] = 1'b0; bc[1] = 1'b0;
        do_txn(3'd0, 3'd6, 32'd11, 36'h100, 0);
        do_txn(3'd4, 3'd6, 32'd12, 36'h100, 4);

        // Misaligned Get and misaligned Put; the latter must not disturb memory.
        do_txn(3'd4, 3'd6, 32'd13, 36'h120, 1);
        bd[0] = rnd256(); bd[1] = rnd256();
        do_txn(3'd0, 3'd6, 32'd14, 36'h120, 0);
        do_txn(3'd4, 3'd6, 32'd15, 36'h100, 0);

        // Unsupported opcode.
        do_txn(3'd6, 3'd0, 32'd16, 36'h0, 0);

        // Reset while a Get is waiting: the response must never appear.
        send_a(3'd4, 3'd5, 32'd17, 36'h40, fc);
        reset = 1'b1;
        #1;
        check("mid_rst_a_ready", a_ready, 1'b0);
        check("mid_rst_d_valid", d_valid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("dropped_d_valid", d_valid, 1'b0);
        end
        check("post_drop_a_ready", a_ready, 1'b1);
        $display("txn reset during WAIT");

        // PutPartial to byte 0 only, then confirm the rest of the entry is intact.
        bd[0] = rnd256(); bm[0] = 32'h1; bc[0] = 1'b0;
        do_txn(3'd1, 3'd5, 32'd18, 36'h0, 0);
        do_txn(3'd4, 3'd5, 32'd19, 36'h0, 0);

        // Randomised traffic over the seeded region.
        for (int t = 0; t < 60; t++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) op = 3'd4;
            sz = 3'($urandom_range(0, 7));
            idx8 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(252, 255));
            addr = {23'($urandom), idx8, 5'($urandom)};
            addr = addr & ~((36'd1 << sz) - 36'd1);
            if (op != 3'd5 && sz != 3'd0 && $urandom_range(0, 4) == 0)
                addr = addr | 36'($urandom_range(1, (1 << int'(sz)) - 1));
            fill_beats(op);
            do_txn(op, sz, $urandom, addr, $urandom_range(0, 2));
        end

        finish_run();
    end

endmodule
